// File: rtl/spi_host.sv
`default_nettype none
// ============================================================================
// Module  : spi_host
// Purpose : Mode-0 SPI master. Turns one register request into one frame:
//           a command word then a data word, both LSB first, with an
//           active-low select, a CLK_DIV-cycle hold after the last bit and
//           a CLK_DIV-cycle deselect gap before the next request is taken.
// Revision: 1.0 - initial release
// ============================================================================
module spi_host #(
    parameter int SPI_CMD_WIDTH  = 8,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int SPI_ADDR_WIDTH = 3,
    parameter int CLK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [SPI_ADDR_WIDTH-1:0] req_addr,
    input  logic [SPI_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [SPI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      spi_clk,
    output logic                      spi_sel,
    output logic                      spi_mosi,
    input  logic                      spi_miso
);

    localparam int c_FRAME_BITS = SPI_CMD_WIDTH + SPI_DATA_WIDTH;
    localparam int c_BIT_W      = (c_FRAME_BITS > 1) ? $clog2(c_FRAME_BITS) : 1;
    localparam int c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(c_FRAME_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_FIRST = c_BIT_W'(SPI_CMD_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                    r_state;
    logic [c_DIV_W-1:0]        r_div;
    logic [c_BIT_W-1:0]        r_bit;
    logic                      r_phase_high;
    logic [c_FRAME_BITS-2:0]   r_frame;      // bits still to be sent after the current one
    logic                      r_is_read;
    logic [SPI_DATA_WIDTH-1:0] r_rx;
    logic                      r_ready;
    logic                      r_rsp_valid;
    logic [SPI_DATA_WIDTH-1:0] r_rsp_rdata;
    logic                      r_spi_clk;
    logic                      r_spi_sel;
    logic                      r_spi_mosi;

    logic [SPI_CMD_WIDTH-1:0]  w_cmd;
    logic [c_FRAME_BITS-1:0]   w_frame;

    // Assemble the full frame from the live request fields; only used at acceptance
    always_comb begin
        w_cmd                     = '0;
        w_cmd[0]                  = req_write;
        w_cmd[SPI_ADDR_WIDTH:1]   = req_addr;
        w_frame = {(req_write ? req_wdata : {SPI_DATA_WIDTH{1'b0}}), w_cmd};
    end

    // Frame sequencer: all serial outputs and handshakes are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_phase_high <= 1'b0;
            r_frame      <= '0;
            r_is_read    <= 1'b0;
            r_rx         <= '0;
            r_ready      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_spi_clk    <= 1'b0;
            r_spi_sel    <= 1'b1;
            r_spi_mosi   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_spi_sel  <= 1'b1;
                    r_spi_clk  <= 1'b0;
                    r_spi_mosi <= 1'b0;
                    if (r_ready && req_valid) begin
                        // Capture everything now so later input changes cannot leak into the frame
                        r_ready      <= 1'b0;
                        r_state      <= S_SHIFT;
                        r_spi_sel    <= 1'b0;
                        r_spi_mosi   <= w_frame[0];
                        r_frame      <= w_frame[c_FRAME_BITS-1:1];
                        r_is_read    <= ~req_write;
                        r_rx         <= '0;
                        r_div        <= '0;
                        r_bit        <= '0;
                        r_phase_high <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (!r_phase_high) begin
                            // Rising spi_clk: slave samples mosi, host samples miso
                            r_spi_clk    <= 1'b1;
                            r_phase_high <= 1'b1;
                            if (r_is_read && (r_bit >= c_DATA_FIRST)) begin
                                r_rx <= {spi_miso, r_rx[SPI_DATA_WIDTH-1:1]};
                            end
                        end else begin
                            // Falling spi_clk: present the next bit for a full low phase
                            r_spi_clk    <= 1'b0;
                            r_phase_high <= 1'b0;
                            if (r_bit == c_BIT_LAST) begin
                                r_state    <= S_HOLD;
                                r_spi_mosi <= 1'b0;
                            end else begin
                                r_bit      <= r_bit + 1'b1;
                                r_spi_mosi <= r_frame[0];
                                r_frame    <= {1'b0, r_frame[c_FRAME_BITS-2:1]};
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div       <= '0;
                        r_state     <= S_GAP;
                        r_spi_sel   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_is_read ? r_rx : '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_GAP: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign spi_clk   = r_spi_clk;
    assign spi_sel   = r_spi_sel;
    assign spi_mosi  = r_spi_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_host.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_host
// Purpose : Scoreboard bench for spi_host. Accepted requests push an expected
//           frame/response; a monitor pops and compares on every rsp_valid.
//           A second instance runs with CLK_DIV=1.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_host;

    localparam int CMD_W    = 8;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int DIV      = 2;
    localparam int NB       = CMD_W + DATA_W;
    localparam int RSP_LAT  = 1 + 2 * DIV * NB + DIV;       // acceptance -> rsp_valid
    localparam int NEXT_ACC = 1 + 2 * DIV * NB + 2 * DIV;   // acceptance -> next acceptance

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- DUT 0 (CLK_DIV=2) ----------------
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              spi_clk;
    logic              spi_sel;
    logic              spi_mosi;
    logic              spi_miso;

    spi_host #(.SPI_CMD_WIDTH(CMD_W), .SPI_DATA_WIDTH(DATA_W),
               .SPI_ADDR_WIDTH(ADDR_W), .CLK_DIV(DIV)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .spi_clk(spi_clk), .spi_sel(spi_sel), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    // ---------------- DUT 1 (CLK_DIV=1) ----------------
    logic              rst1 = 1'b1;
    logic              v1 = 1'b0;
    logic              rdy1;
    logic              w1 = 1'b0;
    logic [ADDR_W-1:0] a1 = '0;
    logic [DATA_W-1:0] d1 = '0;
    logic              rv1;
    logic [DATA_W-1:0] rd1;
    logic              sclk1;
    logic              sel1;
    logic              mosi1;
    bit                d1_done = 1'b0;

    spi_host #(.SPI_CMD_WIDTH(CMD_W), .SPI_DATA_WIDTH(DATA_W),
               .SPI_ADDR_WIDTH(ADDR_W), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst1),
        .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1),
        .rsp_valid(rv1), .rsp_rdata(rd1),
        .spi_clk(sclk1), .spi_sel(sel1), .spi_mosi(mosi1), .spi_miso(1'b1)
    );

    // ---------------- Reference model ----------------
    typedef struct {
        logic [NB-1:0]     frame;
        logic [DATA_W-1:0] rdata;
        int                rsp_cyc;
    } exp_t;

    exp_t sb[$];

    // Frame as an integer: command = write + 2*addr, data word weighted by 2^CMD_W
    function automatic logic [NB-1:0] model_frame(input bit wr, input int addr, input int wd);
        int cmd;
        int data;
        cmd  = (wr ? 1 : 0) + 2 * addr;
        data = wr ? wd : 0;
        return NB'(cmd + data * (1 << CMD_W));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- Slave model ----------------
    logic [DATA_W-1:0] drv_sdata = '0;
    logic [DATA_W-1:0] slave_word = '0;
    int sclk_cnt = 0;

    always @(posedge spi_clk or posedge spi_sel) begin
        if (spi_sel) sclk_cnt <= 0;
        else         sclk_cnt <= sclk_cnt + 1;
    end

    assign spi_miso = (sclk_cnt >= CMD_W && sclk_cnt < NB) ? slave_word[sclk_cnt - CMD_W] : 1'b0;

    // ---------------- Acceptance monitor: push expectations ----------------
    int   last_acc = 0;
    int   prev_acc = 0;
    exp_t acc_e;

    initial forever begin
        @(negedge clk);
        if (!rst && req_valid && req_ready) begin
            acc_e.frame   = model_frame(req_write, int'(req_addr), int'(req_wdata));
            acc_e.rdata   = req_write ? '0 : drv_sdata;
            acc_e.rsp_cyc = cyc + RSP_LAT;
            sb.push_back(acc_e);
            slave_word = drv_sdata;
            prev_acc   = last_acc;
            last_acc   = cyc;
        end
    end

    // ---------------- Response monitor: pop and compare ----------------
    exp_t          mon_e;
    logic [NB-1:0] rx_word = '0;
    int            rx_cnt = 0;
    logic          prev_sclk = 1'b0;
    logic          prev_sel = 1'b1;
    logic [DATA_W-1:0] last_rdata = '0;
    bit            gap_chk = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_rdata = '0;
            rx_cnt     = 0;
            prev_sclk  = 1'b0;
            prev_sel   = 1'b1;
            gap_chk    = 1'b0;
        end else begin
            if (prev_sel && !spi_sel) begin
                rx_cnt  = 0;
                rx_word = '0;
            end
            if (spi_clk && !prev_sclk) begin
                chk("sel low at sclk rise", 32'(spi_sel), 32'd0);
                if (rx_cnt < NB) rx_word[rx_cnt] = spi_mosi;
                rx_cnt++;
            end
            if (spi_sel) begin
                chk("mosi idle low", 32'(spi_mosi), 32'd0);
                chk("sclk idle low", 32'(spi_clk), 32'd0);
            end
            if (req_ready) chk("sel high when ready", 32'(spi_sel), 32'd1);
            if (gap_chk) begin
                chk("gap sel high", 32'(spi_sel), 32'd1);
                chk("gap ready low", 32'(req_ready), 32'd0);
                gap_chk = 1'b0;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected rsp_valid");
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp cycle", 32'(cyc), 32'(mon_e.rsp_cyc));
                    chk("rsp rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                    chk("frame bits", 32'(rx_word), 32'(mon_e.frame));
                    chk("frame bit count", 32'(rx_cnt), 32'(NB));
                    chk("sel high at rsp", 32'(spi_sel), 32'd1);
                    chk("ready low at rsp", 32'(req_ready), 32'd0);
                    gap_chk = 1'b1;
                end
                last_rdata = rsp_rdata;
            end else begin
                chk("rdata hold", 32'(rsp_rdata), 32'(last_rdata));
            end
            if (sb.size() > 0 && cyc > sb[0].rsp_cyc) begin
                fail_now("rsp_valid timeout");
                void'(sb.pop_front());
            end
            prev_sclk = spi_clk;
            prev_sel  = spi_sel;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!req_ready && n < 300) begin
            tick();
            n++;
        end
        ok = req_ready;
        if (!ok) fail_now("req_ready timeout");
    endtask

    task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] sd, input bit junk);
        bit ok;
        int n;
        wait_ready(ok);
        if (ok) begin
            req_valid = 1'b1;
            req_write = wr;
            req_addr  = a;
            req_wdata = wd;
            drv_sdata = sd;
            tick();
            chk("sel low after accept", 32'(spi_sel), 32'd0);
            chk("ready low after accept", 32'(req_ready), 32'd0);
            n = 0;
            while (!req_ready && n < 300) begin
                if (junk) begin
                    req_valid = 1'($urandom);
                    req_write = 1'($urandom);
                    req_addr  = ADDR_W'($urandom);
                    req_wdata = DATA_W'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
                tick();
                n++;
            end
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) fail_now("idle timeout");
    endtask

    // ---------------- Main stimulus (DUT 0) ----------------
    initial begin
        bit ok;
        int t;
        int n;

        rst = 1'b1;
        repeat (3) tick();
        chk("reset sel", 32'(spi_sel), 32'd1);
        chk("reset sclk", 32'(spi_clk), 32'd0);
        chk("reset mosi", 32'(spi_mosi), 32'd0);
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready after reset", 32'(req_ready), 32'd1);

        // Directed write and read
        issue(1'b1, 3'd5, 8'hA5, 8'h00, 1'b0);
        issue(1'b0, 3'd3, 8'hFF, 8'h3C, 1'b0);
        wait_idle();

        // Back-to-back: req_valid held high across two requests
        wait_ready(ok);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 3'd1;
        req_wdata = 8'h96;
        drv_sdata = 8'h00;
        tick();
        req_addr  = 3'd6;
        req_wdata = 8'h81;
        wait_ready(ok);
        tick();
        req_valid = 1'b0;
        wait_idle();
        chk("b2b accept spacing", 32'(last_acc - prev_acc), 32'(NEXT_ACC));

        // Reset in the middle of a read frame
        wait_ready(ok);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 3'd2;
        drv_sdata = 8'h5A;
        tick();
        req_valid = 1'b0;
        t = cyc - 1;
        while (cyc < t + 20) tick();
        rst = 1'b1;
        sb.delete();
        tick();
        chk("midrst sel", 32'(spi_sel), 32'd1);
        chk("midrst sclk", 32'(spi_clk), 32'd0);
        chk("midrst mosi", 32'(spi_mosi), 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready after midrst", 32'(req_ready), 32'd1);
        n = 0;
        while (n < 80) begin
            chk("no rsp after midrst", 32'(rsp_valid), 32'd0);
            tick();
            n++;
        end
        issue(1'b0, 3'd4, 8'h00, 8'hC3, 1'b0);
        wait_idle();

        // Randomized requests with junk on the request bus while busy
        for (int i = 0; i < 20; i++) begin
            issue(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();

        n = 0;
        while (!d1_done && n < 1000) begin
            tick();
            n++;
        end
        if (!d1_done) fail_now("div1 sequence timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- CLK_DIV=1 sequence (DUT 1) ----------------
    initial begin
        int t1;
        int n;
        rst1 = 1'b1;
        repeat (3) tick();
        rst1 = 1'b0;
        tick();
        chk("div1 ready", 32'(rdy1), 32'd1);
        v1 = 1'b1;
        w1 = 1'b0;
        a1 = 3'd7;
        d1 = 8'h00;
        t1 = cyc;
        tick();
        v1 = 1'b0;
        a1 = 3'd0;
        chk("div1 sel low", 32'(sel1), 32'd0);
        for (int k = 0; k < 2 * NB; k++) begin
            chk("div1 sclk toggle", 32'(sclk1), 32'(k % 2));
            tick();
        end
        n = 0;
        while (!rv1 && n < 20) begin
            tick();
            n++;
        end
        if (!rv1) begin
            fail_now("div1 rsp timeout");
        end else begin
            chk("div1 rsp cycle", 32'(cyc), 32'(t1 + 1 + 2 * NB + 1));
            chk("div1 rdata", 32'(rd1), 32'hFF);
        end
        d1_done = 1'b1;
    end

endmodule
`default_nettype wire
